// File: rtl/multicycle_control_fsm.sv
// Main sequencer for the multicycle MIPS datapath: fetch/decode/execute/memory/writeback
// with memory handshake, IR load strobe and all datapath selects/enables.
module multicycle_control_fsm #(
    parameter int MEM_HANDSHAKE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal_op,
    output logic [3:0] state
);

    // state    | meaning
    // FETCH    | read instruction at PC, PC <= PC + 4 when memory completes
    // DECODE   | compute branch target into ALUOut, dispatch on opcode
    // MEMADR   | effective address = regA + sign-extended imm
    // MEMRD    | load data access, wait for memory
    // MEMWB    | write MDR into rt
    // MEMWR    | store data access, wait for memory
    // EXECUTE  | R-type ALU operation on regA/regB
    // ALUWB    | write ALUOut into rd
    // BRANCH   | compare regA/regB, take ALUOut target on zero
    // ADDIEXEC | regA + sign-extended imm
    // ADDIWB   | write ALUOut into rt
    // JUMP     | load jump target into PC
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t state_q;
    state_t state_d;
    logic   ready;

    // Without a handshake every access is assumed to complete in one cycle.
    assign ready = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
    assign state = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = S_FETCH;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        illegal_op = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = ready;
                pc_en     = ready;
                state_d   = ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d    = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                state_d = ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_write = 1'b1;
                state_d   = ready ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                pc_en     = zero;
            end
            S_ADDIEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            S_JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // No write or request may escape while reset is held, whatever the state.
        if (reset) begin
            mem_req    = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            pc_en      = 1'b0;
            reg_write  = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Testbench for multicycle_control_fsm: directed and random instruction streams
// checked cycle by cycle against an instruction-level expected trace.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_write, iord, ir_write, pc_en;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic       alu_src_a, reg_dst, mem_to_reg, reg_write, illegal_op;
    logic [3:0] state;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    multicycle_control_fsm #(.MEM_HANDSHAKE(1)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
        .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    // One expected clock cycle: inputs to drive and the behaviour to observe.
    typedef struct {
        logic [3:0] st;
        logic       mr;
        logic [5:0] opv;
        logic       z;
        logic [5:0] strobes;   // {ir_write, pc_en, reg_write, mem_write, mem_req, illegal_op}
        logic [1:0] pcs;
        logic       io;
        logic       m2r;
        logic       rdst;
        logic       chk_alu;
        logic [1:0] aop;
    } cyc_t;

    cyc_t trace[$];

    function automatic logic is_legal(input logic [5:0] o);
        return (o == OP_R) || (o == OP_J) || (o == OP_BEQ) || (o == OP_ADDI) ||
               (o == OP_LW) || (o == OP_SW);
    endfunction

    // Unconstrained inputs get random values: the controller must ignore them.
    function automatic cyc_t mk(input logic [3:0] st, input logic mr);
        cyc_t c;
        c.st      = st;
        c.mr      = mr;
        c.opv     = 6'($urandom_range(0, 63));
        c.z       = 1'($urandom_range(0, 1));
        c.strobes = 6'b0;
        c.pcs     = 2'b00;
        c.io      = 1'b0;
        c.m2r     = 1'b0;
        c.rdst    = 1'b0;
        c.chk_alu = 1'b0;
        c.aop     = 2'b00;
        return c;
    endfunction

    // Expected trace of one instruction from its class, fetch wait and data wait.
    task automatic build(input logic [5:0] o, input logic z, input int fw, input int mw);
        cyc_t c;
        for (int i = 0; i < fw; i++) begin
            c = mk(4'd0, 1'b0); c.strobes = 6'b000010; trace.push_back(c);
        end
        c = mk(4'd0, 1'b1); c.strobes = 6'b110010; c.pcs = 2'b00; trace.push_back(c);
        c = mk(4'd1, 1'($urandom_range(0, 1))); c.opv = o;
        c.chk_alu = 1'b1; c.aop = 2'b00;
        if (!is_legal(o)) c.strobes = 6'b000001;
        trace.push_back(c);
        if (o == OP_LW || o == OP_SW) begin
            c = mk(4'd2, 1'($urandom_range(0, 1))); c.opv = o; c.chk_alu = 1'b1; trace.push_back(c);
            for (int i = 0; i <= mw; i++) begin
                c = mk((o == OP_LW) ? 4'd3 : 4'd5, (i == mw));
                c.strobes = (o == OP_LW) ? 6'b000010 : 6'b000110;
                c.io = 1'b1;
                trace.push_back(c);
            end
            if (o == OP_LW) begin
                c = mk(4'd4, 1'($urandom_range(0, 1)));
                c.strobes = 6'b001000; c.m2r = 1'b1; c.rdst = 1'b0; trace.push_back(c);
            end
        end else if (o == OP_R) begin
            c = mk(4'd6, 1'($urandom_range(0, 1))); c.chk_alu = 1'b1; c.aop = 2'b10; trace.push_back(c);
            c = mk(4'd7, 1'($urandom_range(0, 1)));
            c.strobes = 6'b001000; c.m2r = 1'b0; c.rdst = 1'b1; trace.push_back(c);
        end else if (o == OP_ADDI) begin
            c = mk(4'd9, 1'($urandom_range(0, 1))); c.chk_alu = 1'b1; c.aop = 2'b00; trace.push_back(c);
            c = mk(4'd10, 1'($urandom_range(0, 1)));
            c.strobes = 6'b001000; c.m2r = 1'b0; c.rdst = 1'b0; trace.push_back(c);
        end else if (o == OP_BEQ) begin
            c = mk(4'd8, 1'($urandom_range(0, 1))); c.z = z;
            c.strobes = {1'b0, z, 4'b0000}; c.pcs = 2'b01; c.chk_alu = 1'b1; c.aop = 2'b01;
            trace.push_back(c);
        end else if (o == OP_J) begin
            c = mk(4'd11, 1'($urandom_range(0, 1)));
            c.strobes = 6'b010000; c.pcs = 2'b10; trace.push_back(c);
        end
    endtask

    // Plays the queued trace; starts and ends at posedge+1 with the DUT in FETCH.
    task automatic run_trace(input string tag);
        cyc_t c;
        logic [5:0] obs;
        while (trace.size() > 0) begin
            c = trace.pop_front();
            mem_ready = c.mr; op = c.opv; zero = c.z;
            @(negedge clk);
            obs = {ir_write, pc_en, reg_write, mem_write, mem_req, illegal_op};
            n_cmp++;
            if (state !== c.st) begin
                n_err++; $display("FAIL %s state: got %0d want %0d", tag, state, c.st);
            end
            n_cmp++;
            if (obs !== c.strobes) begin
                n_err++; $display("FAIL %s strobes(st=%0d): got %b want %b", tag, c.st, obs, c.strobes);
            end
            if (c.strobes[4]) begin
                n_cmp++;
                if (pc_src !== c.pcs) begin
                    n_err++; $display("FAIL %s pc_src(st=%0d): got %b want %b", tag, c.st, pc_src, c.pcs);
                end
            end
            if (c.strobes[1]) begin
                n_cmp++;
                if (iord !== c.io) begin
                    n_err++; $display("FAIL %s iord(st=%0d): got %b want %b", tag, c.st, iord, c.io);
                end
            end
            if (c.strobes[3]) begin
                n_cmp++;
                if ({mem_to_reg, reg_dst} !== {c.m2r, c.rdst}) begin
                    n_err++; $display("FAIL %s wb_sel(st=%0d): got %b%b want %b%b",
                                      tag, c.st, mem_to_reg, reg_dst, c.m2r, c.rdst);
                end
            end
            if (c.chk_alu) begin
                n_cmp++;
                if (alu_op !== c.aop) begin
                    n_err++; $display("FAIL %s alu_op(st=%0d): got %b want %b", tag, c.st, alu_op, c.aop);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; mem_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        reset = 1'b1; mem_ready = 1'b1; op = OP_LW; zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            obs = {ir_write, pc_en, reg_write, mem_write, mem_req, illegal_op};
            n_cmp++;
            if (state !== 4'd0 || obs !== 6'b0) begin
                n_err++; $display("FAIL reset_hold: got st=%0d strobes=%b want st=0 strobes=000000", state, obs);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (state !== 4'd0 || ir_write !== 1'b1 || pc_en !== 1'b1) begin
            n_err++; $display("FAIL reset_release: got st=%0d ir=%b pc_en=%b want 0 1 1", state, ir_write, pc_en);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (state !== 4'd1) begin
            n_err++; $display("FAIL reset_decode: got st=%0d want 1", state);
        end
        @(posedge clk); #1;
        do_reset();
    endtask

    task automatic test_lw();
        build(OP_LW, 1'b0, 0, 0); run_trace("lw");
    endtask

    task automatic test_sw_wait();
        build(OP_SW, 1'b0, 0, 2); run_trace("sw_wait");
    endtask

    task automatic test_branch_jump();
        build(OP_BEQ, 1'b1, 0, 0); run_trace("beq_taken");
        build(OP_BEQ, 1'b0, 0, 0); run_trace("beq_not_taken");
        build(OP_J, 1'b0, 0, 0);   run_trace("jump");
    endtask

    task automatic test_back_to_back();
        build(OP_R, 1'b0, 0, 0);
        build(OP_ADDI, 1'b0, 0, 0);
        run_trace("rtype_addi");
    endtask

    task automatic test_illegal();
        build(6'b111111, 1'b0, 0, 0);
        build(OP_J, 1'b0, 1, 0);
        run_trace("illegal");
    endtask

    task automatic test_reset_midop();
        logic [5:0] obs;
        build(OP_LW, 1'b0, 0, 0);
        void'(trace.pop_back());
        void'(trace.pop_back());
        run_trace("midop_pre");
        mem_ready = 1'b0; op = 6'($urandom_range(0, 63));
        @(negedge clk);
        n_cmp++;
        if (state !== 4'd3 || mem_req !== 1'b1) begin
            n_err++; $display("FAIL midop_memrd: got st=%0d req=%b want 3 1", state, mem_req);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        obs = {ir_write, pc_en, reg_write, mem_write, mem_req, illegal_op};
        n_cmp++;
        if (obs !== 6'b0) begin
            n_err++; $display("FAIL midop_reset_cycle: got strobes=%b want 000000", obs);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (state !== 4'd0 || reg_write !== 1'b0) begin
            n_err++; $display("FAIL midop_after: got st=%0d rw=%b want 0 0", state, reg_write);
        end
        @(posedge clk); #1;
        do_reset();
    endtask

    task automatic test_random();
        logic [5:0] o;
        int k;
        for (int n = 0; n < 80; n++) begin
            k = $urandom_range(0, 6);
            case (k)
                0: o = OP_LW;   1: o = OP_SW;  2: o = OP_R;
                3: o = OP_ADDI; 4: o = OP_BEQ; 5: o = OP_J;
                default: begin
                    o = 6'($urandom_range(0, 63));
                    if (is_legal(o)) o = 6'b111110;
                end
            endcase
            build(o, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));
            run_trace("random");
        end
    endtask

    initial begin
        reset = 1'b1; op = 6'b0; zero = 1'b0; mem_ready = 1'b0;
        test_reset();
        test_lw();
        test_sw_wait();
        test_branch_jump();
        test_back_to_back();
        test_illegal();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main controller of the multicycle MIPS datapath.
- Sequences fetch / decode / execute / memory / writeback, issues memory requests, and generates the IR load strobe (ir_write) plus all datapath selects and write enables.
- Consumes the opcode held in the instruction register (valid from DECODE onward) and the ALU zero flag.

Parameters:
- MEM_HANDSHAKE, 1: 1 = FETCH/MEMRD/MEMWR wait for mem_ready; 0 = mem_ready is ignored and treated as 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- op  in  6  opcode from instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access active
- mem_write  out  1  memory write
- iord  out  1  address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  instruction register load strobe
- pc_en  out  1  PC write enable
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_src_a  out  1  0 = PC, 1 = regA
- alu_src_b  out  2  00 = regB, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2
- alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write
- illegal_op  out  1  one-cycle pulse on unsupported opcode
- state  out  4  current state, for debug

Behaviour:
- Reset: reset and clk as decided. State register ← FETCH (0). While reset is high, all write strobes are forced to 0: ir_write, pc_en, reg_write, mem_write, mem_req, illegal_op.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11. Codes 12-15 return to FETCH on the next clock with all outputs 0.
- Output timing: all outputs are combinational from the state register. ir_write and pc_en in FETCH are also qualified by mem_ready. Every unlisted output is 0.
- FETCH:
  - Outputs: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; ir_write = pc_en = mem_ready.
  - Transition: if mem_ready, go to DECODE; otherwise hold.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00.
  - Next state by op: 100011 (lw) or 101011 (sw) → MEMADR; 000000 → EXECUTE; 000100 → BRANCH; 001000 → ADDIEXEC; 000010 → JUMP.
  - Any other op → FETCH, with illegal_op=1 for this cycle only.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Next state FETCH.
- MEMWR: mem_req=1, iord=1, mem_write=1. Hold until mem_ready, then go to FETCH. mem_write stays high for every wait cycle.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Next state ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero. Next state FETCH.
- ADDIEXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Next state ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1. Next state FETCH.
- JUMP: pc_src=10, pc_en=1. Next state FETCH.
- Cycle counts with zero memory wait: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each wait cycle adds 1.
- Strobe rules:
  - ir_write is asserted for exactly one cycle per instruction.
  - reg_write and mem_write are never both high.
  - pc_en never asserts outside FETCH, BRANCH and JUMP.
- Reset mid-operation: takes effect on the next clock from any state, including memory wait states. No register or memory write strobe is asserted in the reset cycle.
- op is only sampled in DECODE and MEMADR. Changes to op in other states are ignored.

Test Plan:
- Reset held for 3 cycles with mem_ready=1, then released → state=0; ir_write=1 and pc_en=1 in the first post-reset cycle; state=1 in the next cycle.
- lw (op=100011), mem_ready=1 always → states 0,1,2,3,4,0. reg_write=1 with mem_to_reg=1 and reg_dst=0 only in state 4. Total 5 cycles.
- sw (op=101011), mem_ready low for 2 cycles in MEMWR → states 0,1,2,5,5,5,0. mem_write high all three MEMWR cycles. reg_write is never 1.
- beq (op=000100): with zero=1, pc_en=1 and pc_src=01 in state 8; with zero=0, pc_en=0 in state 8. j (op=000010): pc_en=1 and pc_src=10 in state 11.
- R-type (op=000000) then addi (op=001000) → states 0,1,6,7,0,1,9,10. Check alu_op=10 in state 6, reg_dst=1 in state 7, reg_dst=0 in state 10.
- op=111111 → illegal_op=1 for exactly one cycle in DECODE, then state returns to 0. Separately, reset asserted in MEMRD with mem_ready=0 → state=0 next cycle, no reg_write pulse.
